mips_boot_loader: RTL and testbench

//   Upstream feeder for the single-cycle MIPS core. It accepts a program as a

---
 rtl/mips_boot_loader.sv | 76 +++++++
 tb/tb_mips_boot_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: accepts a program as a valid/ready word stream, writes it into
// instruction memory one word per transfer, then pulses start to launch the MIPS core.
module mips_boot_loader #(
   parameter int          DATA_W    = 32,
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_req,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              imem_we,
   output logic [31:0]       imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              start,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);
   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, START, RUN, ERR} state_t;
   localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
   state_t state;
   logic   take;
   // in_ready is only ever high in LOAD, so a transfer implies the LOAD state
   assign take = in_valid & in_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         start      <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
      end else begin
         imem_we <= 1'b0;
         start   <= 1'b0;
         case (state)
            IDLE, RUN, ERR: if (load_req) begin
               state      <= LOAD;
               in_ready   <= 1'b1;
               busy       <= 1'b1;
               err        <= 1'b0;
               word_count <= '0;
            end
            LOAD: if (take) begin
               imem_we    <= 1'b1;
               imem_addr  <= BASE_ADDR + (32'(word_count) << 2);
               imem_wdata <= in_data;
               word_count <= word_count + 1'b1;
               if (in_last) begin
                  state    <= DRAIN;
                  in_ready <= 1'b0;
               end else if (word_count == LAST_SLOT) begin
                  state    <= ERR;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  err      <= 1'b1;
               end
            end
            DRAIN: begin
               state <= START;
               start <= 1'b1;
               busy  <= 1'b0;
            end
            START:   state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_boot_loader.sv
// tb_mips_boot_loader: directed checks of the boot loader, a full-size instance
// plus a 4-word instance for overflow and exact-fill cases.
module tb_mips_boot_loader;
   logic        clk = 1'b0;
   logic        rst_n, load_req, in_valid, in_last;
   logic [31:0] in_data;
   logic        in_ready, imem_we, start, busy, err;
   logic [31:0] imem_addr, imem_wdata;
   logic [10:0] word_count;
   logic        s_in_ready, s_imem_we, s_start, s_busy, s_err;
   logic [31:0] s_imem_addr, s_imem_wdata;
   logic [2:0]  s_word_count;
   int          errors = 0;
   int          checks = 0;
   int          start_cnt = 0;
   int          s_start_cnt = 0;
   logic [31:0] prog [4] = '{32'h20080005, 32'h2009000C, 32'h01095020, 32'hAC0A0000};

   mips_boot_loader dut (
      .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .start(start), .busy(busy),
      .err(err), .word_count(word_count)
   );

   mips_boot_loader #(.ADDR_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(s_in_ready), .imem_we(s_imem_we),
      .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .start(s_start), .busy(s_busy),
      .err(s_err), .word_count(s_word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start) start_cnt++;
      if (s_start) s_start_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({in_ready, imem_we, start, busy, err, word_count} !== 16'h0) begin
         errors++; $display("FAIL reset_idle got %h exp 0", {in_ready, imem_we, start, busy, err, word_count});
      end
      load_req = 1'b1;
      tick();
      load_req = 1'b0; in_valid = 1'b1; in_data = 32'h12345678; in_last = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (imem_we !== 1'b1 || word_count !== 11'd1) begin
         errors++; $display("FAIL pre_reset_write we=%b wc=%0d exp 1/1", imem_we, word_count);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, imem_we, start, busy, err} !== 5'b0 || word_count !== 11'd0) begin
         errors++; $display("FAIL async_reset flags=%b wc=%0d exp 0", {in_ready, imem_we, start, busy, err}, word_count);
      end
      checks++;
      if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
         errors++; $display("FAIL reset_bus addr=%h data=%h exp 0", imem_addr, imem_wdata);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_state_idle ready=%b busy=%b exp 0", in_ready, busy);
      end
   endtask

   task automatic test_load();
      int s0;
      s0 = start_cnt;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || word_count !== 11'd0) begin
         errors++; $display("FAIL load_enter ready=%b busy=%b wc=%0d exp 1/1/0", in_ready, busy, word_count);
      end
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = prog[i]; in_last = (i == 3);
         tick();
         checks++;
         if (imem_we !== 1'b1 || imem_addr !== 32'(4 * i) || imem_wdata !== prog[i] || word_count !== 11'(i + 1)) begin
            errors++; $display("FAIL load_write%0d we=%b addr=%h data=%h wc=%0d exp 1 %h %h %0d",
                               i, imem_we, imem_addr, imem_wdata, word_count, 4 * i, prog[i], i + 1);
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || start !== 1'b0) begin
         errors++; $display("FAIL load_drain ready=%b busy=%b start=%b exp 0/1/0", in_ready, busy, start);
      end
      tick();
      checks++;
      if (start !== 1'b1 || imem_we !== 1'b0 || busy !== 1'b0 || word_count !== 11'd4) begin
         errors++; $display("FAIL load_start start=%b we=%b busy=%b wc=%0d exp 1/0/0/4", start, imem_we, busy, word_count);
      end
      repeat (3) tick();
      checks++;
      if (start_cnt - s0 !== 1 || word_count !== 11'd4 || err !== 1'b0) begin
         errors++; $display("FAIL load_one_pulse pulses=%0d wc=%0d err=%b exp 1/4/0", start_cnt - s0, word_count, err);
      end
   endtask

   task automatic test_reload();
      int s0;
      s0 = start_cnt;
      load_req = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || word_count !== 11'd0) begin
         errors++; $display("FAIL reload_enter ready=%b wc=%0d exp 1/0", in_ready, word_count);
      end
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 32'hA000_0000 + 32'(i); in_last = (i == 1);
         load_req = (i == 0);
         tick();
         checks++;
         if (imem_we !== 1'b1 || imem_addr !== 32'(4 * i) || imem_wdata !== 32'hA000_0000 + 32'(i)) begin
            errors++; $display("FAIL reload_write%0d we=%b addr=%h data=%h exp 1 %h %h",
                               i, imem_we, imem_addr, imem_wdata, 4 * i, 32'hA000_0000 + 32'(i));
         end
      end
      in_valid = 1'b0; in_last = 1'b0; load_req = 1'b0;
      tick();
      checks++;
      if (start !== 1'b1 || word_count !== 11'd2) begin
         errors++; $display("FAIL reload_start start=%b wc=%0d exp 1/2", start, word_count);
      end
      repeat (2) tick();
      checks++;
      if (start_cnt - s0 !== 1) begin
         errors++; $display("FAIL reload_pulses got %0d exp 1", start_cnt - s0);
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] pat = 5'b10101;
      int k = 0;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = pat[4 - c];
         in_data  = in_valid ? 32'hB000_0000 + 32'(k) : 32'hDEADBEEF;
         in_last  = (c == 4);
         tick();
         checks++;
         if (imem_we !== in_valid) begin
            errors++; $display("FAIL bp_we_c%0d got %b exp %b", c, imem_we, in_valid);
         end
         if (in_valid) begin
            checks++;
            if (imem_addr !== 32'(4 * k) || imem_wdata !== 32'hB000_0000 + 32'(k)) begin
               errors++; $display("FAIL bp_write%0d addr=%h data=%h exp %h %h", k, imem_addr, imem_wdata, 4 * k, 32'hB000_0000 + 32'(k));
            end
            k++;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      tick();
      checks++;
      if (start !== 1'b1 || word_count !== 11'd3) begin
         errors++; $display("FAIL bp_start start=%b wc=%0d exp 1/3", start, word_count);
      end
      tick();
   endtask

   task automatic test_overflow();
      int s0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      s0 = s_start_cnt;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 32'hC000_0000 + 32'(i); in_last = 1'b0;
         tick();
         checks++;
         if (s_imem_we !== 1'b1 || s_imem_addr !== 32'(4 * i) || s_imem_wdata !== 32'hC000_0000 + 32'(i)) begin
            errors++; $display("FAIL ovf_write%0d we=%b addr=%h data=%h exp 1 %h %h",
                               i, s_imem_we, s_imem_addr, s_imem_wdata, 4 * i, 32'hC000_0000 + 32'(i));
         end
      end
      checks++;
      if (s_err !== 1'b1 || s_in_ready !== 1'b0 || s_busy !== 1'b0 || s_word_count !== 3'd4) begin
         errors++; $display("FAIL ovf_err err=%b ready=%b busy=%b wc=%0d exp 1/0/0/4", s_err, s_in_ready, s_busy, s_word_count);
      end
      tick();
      checks++;
      if (s_imem_we !== 1'b0) begin
         errors++; $display("FAIL ovf_no_extra_write got %b exp 0", s_imem_we);
      end
      in_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if (s_start_cnt - s0 !== 0 || s_err !== 1'b1) begin
         errors++; $display("FAIL ovf_no_start pulses=%0d err=%b exp 0/1", s_start_cnt - s0, s_err);
      end
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      checks++;
      if (s_err !== 1'b0 || s_in_ready !== 1'b1 || s_word_count !== 3'd0) begin
         errors++; $display("FAIL ovf_reload err=%b ready=%b wc=%0d exp 0/1/0", s_err, s_in_ready, s_word_count);
      end
      in_valid = 1'b1; in_data = 32'hC1C1C1C1; in_last = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      checks++;
      if (s_imem_we !== 1'b1 || s_imem_addr !== 32'h0 || s_imem_wdata !== 32'hC1C1C1C1) begin
         errors++; $display("FAIL ovf_restart_addr we=%b addr=%h data=%h exp 1 0 c1c1c1c1", s_imem_we, s_imem_addr, s_imem_wdata);
      end
      repeat (3) tick();
   endtask

   task automatic test_exact_fill();
      int s0;
      s0 = s_start_cnt;
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 32'hD000_0000 + 32'(i); in_last = (i == 3);
         tick();
         checks++;
         if (s_imem_we !== 1'b1 || s_imem_addr !== 32'(4 * i) || s_err !== 1'b0) begin
            errors++; $display("FAIL fill_write%0d we=%b addr=%h err=%b exp 1 %h 0", i, s_imem_we, s_imem_addr, s_err, 4 * i);
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      checks++;
      if (s_busy !== 1'b1 || s_err !== 1'b0) begin
         errors++; $display("FAIL fill_drain busy=%b err=%b exp 1/0", s_busy, s_err);
      end
      tick();
      checks++;
      if (s_start !== 1'b1 || s_err !== 1'b0 || s_word_count !== 3'd4) begin
         errors++; $display("FAIL fill_start start=%b err=%b wc=%0d exp 1/0/4", s_start, s_err, s_word_count);
      end
      repeat (2) tick();
      checks++;
      if (s_start_cnt - s0 !== 1) begin
         errors++; $display("FAIL fill_pulses got %0d exp 1", s_start_cnt - s0);
      end
   endtask

   initial begin
      rst_n = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_load();
      test_reload();
      test_backpressure();
      test_overflow();
      test_exact_fill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
